// File: rtl/arm7tdmi_pkg.sv
// Types shared by the multiplier, the decoder and the reference multiply block.
package arm7tdmi_pkg;

  typedef enum logic [1:0] {
    MUL_TYPE_MUL  = 2'b00,
    MUL_TYPE_MLA  = 2'b01,
    MUL_TYPE_MULL = 2'b10,
    MUL_TYPE_MLAL = 2'b11
  } mul_type_t;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_CALC,
    MUL_DONE
  } mul_state_t;

  // Long forms produce a 2W result and flags from the full accumulator.
  function automatic logic mul_is_long(mul_type_t t);
    return (t == MUL_TYPE_MULL) || (t == MUL_TYPE_MLAL);
  endfunction

endpackage

// File: rtl/arm7tdmi_multiply_iter_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
interface arm7tdmi_multiply_iter_if #(
  parameter int WIDTH = 32
);
  import arm7tdmi_pkg::*;

  logic             req_valid;
  logic             req_ready;
  mul_type_t        mul_type;
  logic             mul_signed;
  logic             mul_set_flags;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             negative;
  logic             zero;
  logic [3:0]       calc_cycles;

  modport master (
    output req_valid, mul_type, mul_signed, mul_set_flags,
           operand_a, operand_b, acc_hi, acc_lo, rsp_ready,
    input  req_ready, rsp_valid, result_hi, result_lo, negative, zero, calc_cycles
  );

  modport slave (
    input  req_valid, mul_type, mul_signed, mul_set_flags,
           operand_a, operand_b, acc_hi, acc_lo, rsp_ready,
    output req_ready, rsp_valid, result_hi, result_lo, negative, zero, calc_cycles
  );

endinterface

// File: rtl/arm7tdmi_mul_step.sv
// One multiplier-chunk step: retires chunk k of b into the 2W accumulator and flags termination.
// Purely combinational; no backpressure.
module arm7tdmi_mul_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 8,
  parameter int EARLY_TERM     = 1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         k,
  input  logic               sgn,
  input  logic [2*WIDTH-1:0] acc,
  output logic               term,
  output logic [2*WIDTH-1:0] acc_next
);

  localparam int B = BITS_PER_CYCLE;
  localparam int N = WIDTH / BITS_PER_CYCLE;

  logic [B-1:0]       chunk;
  logic               fill;
  logic               upper_fill;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] d_ext;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    chunk = B'(b >> (int'(k) * B));
    fill  = sgn & chunk[B-1];

    // Remaining multiplier bits must all equal the fill bit for the product to be complete.
    upper_fill = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i >= (int'(k) + 1) * B) && (b[i] != fill)) begin
        upper_fill = 1'b0;
      end
    end

    term = (int'(k) == N - 1) || ((EARLY_TERM != 0) && upper_fill);

    a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    // Only the final chunk of a signed multiplier carries negative weight.
    d_ext = (sgn && term) ? {{(2*WIDTH-B){chunk[B-1]}}, chunk}
                          : {{(2*WIDTH-B){1'b0}}, chunk};
    prod     = a_ext * d_ext;
    acc_next = acc + (prod << (int'(k) * B));
  end

endmodule

// File: rtl/arm7tdmi_multiply_iter.sv
// Iterative MUL/MLA/MULL/MLAL unit retiring BITS_PER_CYCLE multiplier bits per CALC cycle.
// Latency 1..N CALC cycles (early termination); result held in DONE until rsp_ready, no request accepted while busy.
module arm7tdmi_multiply_iter
  import arm7tdmi_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 8,
  parameter int EARLY_TERM     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    abort,
  arm7tdmi_multiply_iter_if.slave bus
);

  typedef struct packed {
    mul_type_t        typ;
    logic             sgn;
    logic             set_flags;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  mul_state_t         state, state_nxt;
  req_t               req;
  logic [3:0]         k;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic               term;
  logic [WIDTH-1:0]   result_hi, result_lo;
  logic               negative, zero;
  logic [3:0]         calc_cycles;

  arm7tdmi_mul_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE),
    .EARLY_TERM    (EARLY_TERM)
  ) u_step (
    .a       (req.a),
    .b       (req.b),
    .k       (k),
    .sgn     (req.sgn),
    .acc     (acc),
    .term    (term),
    .acc_next(acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst || abort) state <= MUL_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      MUL_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = MUL_CALC;
      end
      MUL_CALC: begin
        if (term) state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = MUL_IDLE;
      end
      default: state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      req         <= '0;
      k           <= '0;
      acc         <= '0;
      result_hi   <= '0;
      result_lo   <= '0;
      negative    <= 1'b0;
      zero        <= 1'b0;
      calc_cycles <= '0;
    end else if (state == MUL_IDLE && bus.req_valid) begin
      req <= '{typ: bus.mul_type, sgn: bus.mul_signed, set_flags: bus.mul_set_flags,
               a: bus.operand_a, b: bus.operand_b};
      k   <= '0;
      case (bus.mul_type)
        MUL_TYPE_MLAL: acc <= {bus.acc_hi, bus.acc_lo};
        MUL_TYPE_MLA:  acc <= {{WIDTH{1'b0}}, bus.acc_lo};
        default:       acc <= '0;
      endcase
    end else if (state == MUL_CALC) begin
      acc <= acc_next;
      k   <= k + 4'd1;
      if (term) begin
        calc_cycles <= k + 4'd1;
        result_lo   <= acc_next[WIDTH-1:0];
        if (mul_is_long(req.typ)) begin
          result_hi <= acc_next[2*WIDTH-1:WIDTH];
          negative  <= req.set_flags & acc_next[2*WIDTH-1];
          zero      <= req.set_flags & (acc_next == '0);
        end else begin
          result_hi <= '0;
          negative  <= req.set_flags & acc_next[WIDTH-1];
          zero      <= req.set_flags & (acc_next[WIDTH-1:0] == '0);
        end
      end
    end
  end

  assign bus.result_hi   = result_hi;
  assign bus.result_lo   = result_lo;
  assign bus.negative    = negative;
  assign bus.zero        = zero;
  assign bus.calc_cycles = calc_cycles;

endmodule

// File: tb/tb_arm7tdmi_multiply_iter.sv
// Directed and random checks of the iterative multiplier against a 64-bit reference model.
module tb_arm7tdmi_multiply_iter;
  import arm7tdmi_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        n;
    logic        z;
    logic [3:0]  cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic abort;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t last_exp;

  arm7tdmi_multiply_iter_if #(.WIDTH(32)) bus ();

  arm7tdmi_multiply_iter #(
    .WIDTH(32), .BITS_PER_CYCLE(8), .EARLY_TERM(1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .abort(abort),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(mul_type_t t, logic s, logic f,
                                 logic [31:0] a, logic [31:0] b,
                                 logic [31:0] ahi, logic [31:0] alo);
    exp_t        e;
    logic [63:0] p, acc, r;
    int          sbv;
    if (s) p = 64'($signed(a)) * 64'($signed(b));
    else   p = {32'd0, a} * {32'd0, b};
    acc = (t == MUL_TYPE_MLAL) ? {ahi, alo} : (t == MUL_TYPE_MLA) ? {32'd0, alo} : 64'd0;
    r = p + acc;
    if (t == MUL_TYPE_MULL || t == MUL_TYPE_MLAL) begin
      e.hi = r[63:32];
      e.n  = f & r[63];
      e.z  = f & (r == 64'd0);
    end else begin
      e.hi = 32'd0;
      e.n  = f & r[31];
      e.z  = f & (r[31:0] == 32'd0);
    end
    e.lo = r[31:0];
    // Cycles = smallest number of bytes that represents b in the requested signedness.
    e.cyc = 4'd4;
    sbv = b;
    for (int n = 3; n >= 1; n--) begin
      if (s) begin
        if (((sbv <<< (32 - 8 * n)) >>> (32 - 8 * n)) == sbv) e.cyc = 4'(n);
      end else begin
        if ((b >> (8 * n)) == 32'd0) e.cyc = 4'(n);
      end
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic issue(input mul_type_t t, input logic s, input logic f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ahi, input logic [31:0] alo, input logic push);
    if (push) sb.push_back(model(t, s, f, a, b, ahi, alo));
    bus.mul_type      = t;
    bus.mul_signed    = s;
    bus.mul_set_flags = f;
    bus.operand_a     = a;
    bus.operand_b     = b;
    bus.acc_hi        = ahi;
    bus.acc_lo        = alo;
    bus.req_valid     = 1'b1;
    check("req_ready_idle", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic collect();
    int   cnt = 0;
    exp_t e;
    while (!bus.rsp_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("rsp_valid", bus.rsp_valid, 1'b1);
    e = sb.pop_front();
    last_exp = e;
    check("latency", 64'(cnt), 64'(e.cyc));
    check("calc_cycles", bus.calc_cycles, e.cyc);
    check("result_hi", bus.result_hi, e.hi);
    check("result_lo", bus.result_lo, e.lo);
    check("negative", bus.negative, e.n);
    check("zero", bus.zero, e.z);
  endtask

  task automatic run_op(input mul_type_t t, input logic s, input logic f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ahi, input logic [31:0] alo);
    issue(t, s, f, a, b, ahi, alo, 1'b1);
    collect();
    @(negedge clk);
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra, rb, rhi, rlo;
    rst = 1'b1;
    abort = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.mul_type = MUL_TYPE_MUL;
    bus.mul_signed = 1'b0;
    bus.mul_set_flags = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.acc_hi = '0;
    bus.acc_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    check("rst_cycles", bus.calc_cycles, 4'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(MUL_TYPE_MULL, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(MUL_TYPE_MULL, 1'b1, 1'b0, 32'd5, 32'hFFFFFF80, 0, 0);
    run_op(MUL_TYPE_MULL, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd2, 0, 0);
    run_op(MUL_TYPE_MUL, 1'b0, 1'b1, 32'h00010000, 32'h00010000, 0, 0);
    run_op(MUL_TYPE_MLA, 1'b0, 1'b0, 32'd3, 32'd5, 0, 32'd7);
    run_op(MUL_TYPE_MLAL, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF);
    run_op(MUL_TYPE_MLAL, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 32'h12345678, 32'h9ABCDEF0);

    // Back-pressure: result held, new requests ignored.
    bus.rsp_ready = 1'b0;
    issue(MUL_TYPE_MLA, 1'b1, 1'b1, 32'hFFFFFFF0, 32'h00001234, 0, 32'd99, 1'b1);
    collect();
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.operand_a = 32'd7;
      bus.operand_b = 32'd9;
      @(negedge clk);
      check("bp_rsp_valid", bus.rsp_valid, 1'b1);
      check("bp_req_ready", bus.req_ready, 1'b0);
      check("bp_result_lo", bus.result_lo, last_exp.lo);
      check("bp_negative", bus.negative, last_exp.n);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", bus.rsp_valid, 1'b0);
    check("bp_release_ready", bus.req_ready, 1'b1);
    check("bp_hold_lo", bus.result_lo, last_exp.lo);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("bp_ignored_req", seen, 1'b0);

    // Abort during the second CALC cycle of a four-cycle UMULL.
    issue(MUL_TYPE_MULL, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_req_ready", bus.req_ready, 1'b1);
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check("abort_result", {bus.result_hi, bus.result_lo}, 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("abort_no_rsp", seen, 1'b0);

    // Leave non-zero outputs behind, then reset mid-CALC.
    run_op(MUL_TYPE_MULL, 1'b0, 1'b1, 32'h12345678, 32'h87654321, 0, 0);
    issue(MUL_TYPE_MULL, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_result", {bus.result_hi, bus.result_lo}, 64'd0);
    check("rst_mid_flags", {bus.negative, bus.zero}, 2'b00);
    check("rst_mid_cycles", bus.calc_cycles, 4'd0);
    check("rst_mid_valid", bus.rsp_valid, 1'b0);
    check("rst_mid_ready", bus.req_ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) rb = ~rb;
      rhi = $urandom;
      rlo = $urandom;
      run_op(mul_type_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ra, rb, rhi, rlo);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
